rom_port_arbiter: RTL

Two-master arbiter that shares the program ROM's single data read/write port between the core load/store unit (master 0) and the serial program loader (master 1). Per cycle it grants at most one requester, drives the ROM write/read-address inputs, and routes the ROM's one-cycle-latency read data back to the issuing master with a valid strobe. A loader lock mode gives master 1 exclusive ownership for a download session and stalls the core for its duration.

---
 rtl/rom_arb_pkg.sv | 15 +
 rtl/rom_arb_rr2.sv | 30 +++
 rtl/rom_port_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the program-ROM port arbiter.
package rom_arb_pkg;

    typedef enum logic {ARB = 1'b0, LOCK = 1'b1} arb_state_e;

    localparam logic M_CORE   = 1'b0;
    localparam logic M_LOAD   = 1'b1;
    localparam int   WORD_LSB = 2;

    // Misaligned or beyond the last ROM word.
    function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] depth);
        return (addr[WORD_LSB-1:0] != '0) || ({2'b00, addr[31:WORD_LSB]} >= depth);
    endfunction

endpackage

// File: rtl/rom_arb_rr2.sv
// Two-input round-robin grant with a one-bit pointer favouring the master it names.
module rom_arb_rr2
    import rom_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       ptr_clr,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = '0;
        if (en) begin
            if (req == 2'b11) gnt[ptr] = 1'b1;
            else              gnt      = req;
        end
    end

    // After any grant the pointer moves to the master that was not served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          ptr <= M_CORE;
        else if (ptr_clr) ptr <= M_CORE;
        else if (|gnt)    ptr <= gnt[0] ? M_LOAD : M_CORE;
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the program ROM's single port between the core LSU (m0) and the serial loader (m1),
// with a loader lock mode that stalls the core for a whole download session.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,
    input  logic        m1_lock_i,
    output logic        core_stall_o,
    output logic        wr_en_o,
    output logic [31:0] wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic [31:0] rd_addr_o,
    input  logic [31:0] rd_data_i
);

    arb_state_e  state_q, state_d;
    logic        rr_en, ptr_clr;
    logic [1:0]  rr_gnt;
    logic        acc, sel, sel_we, acc_err;
    logic [31:0] sel_addr, sel_wdata, rdata;
    logic        pend_q, owner_q, err_q, rd_q;

    assign rr_en = (state_q == ARB) && !m1_lock_i;

    rom_arb_rr2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .en      (rr_en),
        .ptr_clr (ptr_clr),
        .req     ({m1_req_i, m0_req_i}),
        .gnt     (rr_gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ARB;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        m0_gnt_o = 1'b0;
        m1_gnt_o = 1'b0;
        ptr_clr  = 1'b0;
        case (state_q)
            ARB: begin
                if (m1_lock_i) begin
                    m1_gnt_o = m1_req_i;
                    state_d  = LOCK;
                end else begin
                    m0_gnt_o = rr_gnt[0];
                    m1_gnt_o = rr_gnt[1];
                end
            end
            LOCK: begin
                m1_gnt_o = m1_req_i;
                // Leaving lock hands the next contended slot to the stalled core.
                if (!m1_lock_i) begin
                    state_d = ARB;
                    ptr_clr = 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    assign core_stall_o = (state_q == LOCK);

    assign acc       = m0_gnt_o | m1_gnt_o;
    assign sel       = m1_gnt_o;
    assign sel_we    = sel ? m1_we_i    : m0_we_i;
    assign sel_addr  = sel ? m1_addr_i  : m0_addr_i;
    assign sel_wdata = sel ? m1_wdata_i : m0_wdata_i;
    assign acc_err   = acc && addr_err(sel_addr, 32'(DEPTH));

    assign wr_en_o   = acc && sel_we && !acc_err;
    assign wr_addr_o = acc ? sel_addr  : '0;
    assign wr_data_o = acc ? sel_wdata : '0;
    assign rd_addr_o = acc ? sel_addr  : '0;

    // Response bookkeeping for the transaction accepted last cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= 1'b0;
            owner_q <= M_CORE;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            pend_q  <= acc;
            owner_q <= sel;
            err_q   <= acc_err;
            rd_q    <= acc && !sel_we;
        end
    end

    assign rdata       = (pend_q && rd_q && !err_q) ? rd_data_i : '0;
    assign m0_rvalid_o = pend_q && (owner_q == M_CORE);
    assign m1_rvalid_o = pend_q && (owner_q == M_LOAD);
    assign m0_rdata_o  = m0_rvalid_o ? rdata : '0;
    assign m1_rdata_o  = m1_rvalid_o ? rdata : '0;
    assign m0_err_o    = m0_rvalid_o && err_q;
    assign m1_err_o    = m1_rvalid_o && err_q;

endmodule
